// File: rtl/upscale_pkg.sv
// Shared types and constants for the 2x nearest-neighbour upscaler line controller.
package upscale_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LINE_W = 16;

  // Index width for a line of n pixels; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upscale_line_buf.sv
// Line storage: LINE_W x DATA_W register bank, one write port, one read port.
// Storage is deliberately left unreset; it is always filled before it is read.
module upscale_line_buf
  import upscale_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int IDX_W  = idx_width(LINE_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [LINE_W];

  // Each entry either reloads itself or takes the write data when addressed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LINE_W; i++) begin
      mem[i] <= (we && (wr_idx == IDX_W'(i))) ? wr_data : mem[i];
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/upscale2x_line_ctrl.sv
// Line-buffer controller for the 2x nearest-neighbour upscaler.
// Fills one row of LINE_W pixels, then replays it as two rows with every
// pixel doubled. Optional row-length check: define UPSCALE_LAST_CHECK_EN.
module upscale2x_line_ctrl
  import upscale_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_eol
`ifdef UPSCALE_LAST_CHECK_EN
  ,
  input  logic              s_last,
  output logic              err
`endif
);

  localparam int IDX_W = idx_width(LINE_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_W - 1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  wr_idx, wr_idx_n;
  logic [IDX_W-1:0]  rd_idx, rd_idx_n;
  logic [IDX_W-1:0]  rd_addr;
  logic              dup, dup_n;
  logic              m_valid_n, m_eol_n;
  logic [DATA_W-1:0] m_data_n;
  logic [DATA_W-1:0] rd_data;
  logic              s_fire, m_fire, eol_beat;

  assign s_ready  = (state == FILL);
  assign s_fire   = s_valid & s_ready;
  assign m_fire   = m_valid & m_ready;
  assign eol_beat = (rd_idx == LAST) & dup;

  upscale_line_buf #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk     (clk),
    .we      (s_fire),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .rd_idx  (rd_addr),
    .rd_data (rd_data)
  );

  // Read address is the pixel the next output beat will need when it advances.
  always_comb begin
    rd_addr = '0;
    if (state != FILL && !eol_beat && dup) begin
      rd_addr = rd_idx + IDX_W'(1);
    end
  end

  // Next-state, counter and output-register logic.
  always_comb begin
    state_n   = state;
    wr_idx_n  = wr_idx;
    rd_idx_n  = rd_idx;
    dup_n     = dup;
    m_valid_n = m_valid;
    m_eol_n   = m_eol;
    m_data_n  = m_data;
    case (state)
      FILL: begin
        if (s_fire) begin
          if (wr_idx == LAST) begin
            wr_idx_n  = '0;
            rd_idx_n  = '0;
            dup_n     = 1'b0;
            state_n   = EMIT0;
            m_valid_n = 1'b1;
            m_data_n  = rd_data;
            m_eol_n   = 1'b0;
          end else begin
            wr_idx_n = wr_idx + IDX_W'(1);
          end
        end
      end
      EMIT0, EMIT1: begin
        if (m_fire) begin
          if (eol_beat) begin
            rd_idx_n = '0;
            dup_n    = 1'b0;
            m_eol_n  = 1'b0;
            if (state == EMIT0) begin
              state_n  = EMIT1;
              m_data_n = rd_data;
            end else begin
              state_n   = FILL;
              m_valid_n = 1'b0;
            end
          end else if (!dup) begin
            dup_n   = 1'b1;
            m_eol_n = (rd_idx == LAST);
          end else begin
            rd_idx_n = rd_idx + IDX_W'(1);
            dup_n    = 1'b0;
            m_data_n = rd_data;
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  // State, counters and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      wr_idx  <= '0;
      rd_idx  <= '0;
      dup     <= 1'b0;
      m_valid <= 1'b0;
      m_eol   <= 1'b0;
      m_data  <= '0;
    end else begin
      state   <= state_n;
      wr_idx  <= wr_idx_n;
      rd_idx  <= rd_idx_n;
      dup     <= dup_n;
      m_valid <= m_valid_n;
      m_eol   <= m_eol_n;
      m_data  <= m_data_n;
    end
  end

`ifdef UPSCALE_LAST_CHECK_EN
  // Sticky flag: s_last must be high exactly on the final pixel of a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (s_fire && (s_last != (wr_idx == LAST))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_upscale2x_line_ctrl.sv
// Bench for upscale2x_line_ctrl with DATA_W=8, LINE_W=4.
// Row-check scenario is compiled when UPSCALE_LAST_CHECK_EN is defined.
module tb_upscale2x_line_ctrl;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_eol;
`ifdef UPSCALE_LAST_CHECK_EN
  logic       s_last;
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  upscale2x_line_ctrl #(
    .DATA_W (8),
    .LINE_W (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_eol   (m_eol)
`ifdef UPSCALE_LAST_CHECK_EN
    ,
    .s_last  (s_last),
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_m_valid"}, m_valid, 1'b0);
    check_output({tag, "_m_eol"},   m_eol,   1'b0);
    check_output({tag, "_m_data"},  m_data,  8'h00);
    check_output({tag, "_s_ready"}, s_ready, 1'b1);
  endtask

  // Assert reset a few ns after a falling edge, well away from any rising edge.
  task automatic mid_cycle_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Feed one row, then consume and score its output. abort_after >= 0 returns
  // at the negedge where that many output beats have been taken.
  task automatic apply_row(input logic [7:0] p [4], input int gap, input int bp_pct,
                           input int abort_after, input int bad_idx);
    logic [7:0] exp_d [$];
    logic       exp_e [$];
    int         beats;
    int         cycles;
    bit         done;
    bit         finished;
    bit         prev_stall;
    logic [7:0] prev_d;
    logic       prev_e;

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 2; k++) begin
          exp_d.push_back(p[i]);
          exp_e.push_back((i == 3) && (k == 1));
        end

    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          @(negedge clk);
          s_valid = 1'b0;
          s_data  = 8'($urandom);
          check_output("gap_s_ready", s_ready, 1'b1);
          check_output("gap_m_valid", m_valid, 1'b0);
        end
      end
      @(negedge clk);
      check_output("fill_s_ready", s_ready, 1'b1);
      check_output("fill_m_valid", m_valid, 1'b0);
      s_valid = 1'b1;
      s_data  = p[i];
`ifdef UPSCALE_LAST_CHECK_EN
      s_last  = (i == 3) || (i == bad_idx);
`else
      if (bad_idx >= 0) $display("[TB] row check disabled in this build");
`endif
    end

    beats      = 0;
    done       = 1'b0;
    finished   = 1'b0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_e     = 1'b0;
    for (cycles = 0; cycles < 400; cycles++) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
`ifdef UPSCALE_LAST_CHECK_EN
      s_last  = 1'b0;
`endif
      if (done) begin
        check_output("refill_m_valid", m_valid, 1'b0);
        check_output("refill_s_ready", s_ready, 1'b1);
        finished = 1'b1;
        break;
      end
      if (beats == abort_after) return;
      check_output("emit_m_valid", m_valid, 1'b1);
      check_output("emit_s_ready", s_ready, 1'b0);
      if (prev_stall) begin
        check_output("stall_m_data", m_data, prev_d);
        check_output("stall_m_eol",  m_eol,  prev_e);
      end
      m_ready = ($urandom_range(99) >= bp_pct);
      if (m_valid && m_ready) begin
        check_output($sformatf("beat%0d_data", beats), m_data, exp_d.pop_front());
        check_output($sformatf("beat%0d_eol", beats),  m_eol,  exp_e.pop_front());
        beats++;
        if (beats == 16) done = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_e     = m_eol;
    end
    check_output("row_complete", finished, 1'b1);
    if (bp_pct == 0) check_output("row_emit_cycles", cycles, 16);
  endtask

  initial begin
    logic [7:0] row [4];

    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
`ifdef UPSCALE_LAST_CHECK_EN
    s_last  = 1'b0;
`endif

    // Scenario 1: asynchronous reset mid-cycle.
    #12 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
`ifdef UPSCALE_LAST_CHECK_EN
    check_output("reset_err", err, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 2: unthrottled row.
    apply_row('{8'h10, 8'h20, 8'h30, 8'h40}, 0, 0, -1, -1);

    // Scenario 3: random backpressure around 50%.
    apply_row('{8'h10, 8'h20, 8'h30, 8'h40}, 0, 50, -1, -1);

    // Scenario 4: three idle clocks between input pixels.
    apply_row('{8'h10, 8'h20, 8'h30, 8'h40}, 3, 0, -1, -1);

    // Scenario 5: reset on beat 5 of the first replay row.
    for (int i = 0; i < 4; i++) row[i] = 8'($urandom);
    apply_row(row, 0, 0, 4, -1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrow_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply_row('{8'h01, 8'h02, 8'h03, 8'h04}, 0, 0, -1, -1);

    // Random rows with random gaps and backpressure.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) row[i] = 8'($urandom);
      apply_row(row, int'($urandom_range(2)), int'($urandom_range(70)), -1, -1);
    end

`ifdef UPSCALE_LAST_CHECK_EN
    // Scenario 6: early s_last sets the sticky error flag.
    for (int i = 0; i < 4; i++) row[i] = 8'($urandom);
    apply_row(row, 0, 0, -1, 1);
    check_output("err_set", err, 1'b1);
    apply_row(row, 0, 30, -1, -1);
    check_output("err_sticky", err, 1'b1);
    mid_cycle_reset("err_reset");
    check_output("err_cleared", err, 1'b0);
    apply_row(row, 0, 0, -1, -1);
    check_output("err_clean_row", err, 1'b0);
`else
    mid_cycle_reset("final_reset");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upscale2x_line_ctrl.md
# upscale2x_line_ctrl

- Line-buffer controller for the 2x nearest-neighbour upscaler.
- Captures one input row of `LINE_W` pixels into a local register bank, then replays it as two output rows, emitting every pixel twice per row.
- Sits between the pixel input stream and the downstream output stream.
- Sequences fill and replay so the shared line storage is never written while it is being read.

## Interface

Parameters:
- `DATA_W`, 8: pixel width in bits.
- `LINE_W`, 16: pixels per input row; must be at least 2.

Ports:
- `clk`  in  1  Single clock; all logic is rising-edge triggered.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `s_valid`  in  1  Input pixel valid.
- `s_ready`  out  1  Controller accepts an input pixel.
- `s_data`  in  `DATA_W`  Input pixel.
- `m_valid`  out  1  Output pixel valid.
- `m_ready`  in  1  Downstream accepts an output pixel.
- `m_data`  out  `DATA_W`  Output pixel.
- `m_eol`  out  1  Marks the last beat of each output row.
- `s_last`  in  1  Input end-of-row flag; present only with `UPSCALE_LAST_CHECK_EN`.
- `err`  out  1  Sticky row-length error; present only with `UPSCALE_LAST_CHECK_EN`.

## Operation

- States: FILL, EMIT0, EMIT1.
- FILL:
  - `s_ready=1`, `m_valid=0`.
  - Each handshake (`s_valid & s_ready`) writes `s_data` to `buf[wr_idx]`, then `wr_idx++`.
  - The handshake at `wr_idx==LINE_W-1` clears `wr_idx` and moves to EMIT0.
- EMIT0 and EMIT1:
  - `s_ready=0`.
  - Output order per row: `buf[0],buf[0],buf[1],buf[1],…,buf[LINE_W-1],buf[LINE_W-1]`, i.e. `2*LINE_W` beats.
  - A `dup` bit toggles on each output handshake; `rd_idx` increments when `dup` goes 1→0.
  - `m_eol=1` only on the beat where `rd_idx==LINE_W-1` and `dup==1`.
  - The handshake on the EOL beat goes EMIT0→EMIT1 (`rd_idx`/`dup` cleared) or EMIT1→FILL.
- Each input row produces exactly `4*LINE_W` output beats.
- Output handshake rule: while `m_valid & !m_ready`, `m_data`, `m_eol` and `m_valid` hold stable.
- Input and output never handshake in the same cycle; the states are mutually exclusive.
- Arithmetic:
  - `wr_idx` and `rd_idx` are `$clog2(LINE_W)` bits.
  - Explicit compare to `LINE_W-1`; no reliance on natural wrap, since `LINE_W` need not be a power of 2.
- Reset values:
  - state FILL, `s_ready=1` (combinational from state), `m_valid=0`, `m_data=0`, `m_eol=0`.
  - `wr_idx=0`, `rd_idx=0`, `dup=0`, `err=0`.
  - Buffer contents are not reset.
- Reset mid-operation: everything returns to reset values immediately and the partial row is discarded. The first accepted pixel after `rst_n` rises is pixel 0 of a new row.

## Timing

- `m_valid`, `m_data` and `m_eol` are registered.
- Fill rate is 1 pixel/clk when `s_valid` is held high.
- Latency: the last FILL handshake at edge N gives `m_valid=1`, `m_data=buf[0]` from edge N+1.
- Throughput is 1 beat/clk with `m_ready=1`; EMIT0→EMIT1 has no bubble.
- Transition back to FILL:
  - EMIT1 EOL handshake at edge M.
  - `m_valid=0` and `s_ready=1` from edge M+1.
  - The next row can be accepted in cycle M+1.
- Row period with both sides unthrottled: `LINE_W + 4*LINE_W` clks.

## Configuration

- `UPSCALE_LAST_CHECK_EN` defined:
  - Adds the `s_last` and `err` ports.
  - On each FILL handshake, `err` is set if `s_last != (wr_idx==LINE_W-1)`.
  - `err` is sticky and cleared only by `rst_n`.
  - Data path and sequencing are unchanged; row length stays `LINE_W`.
- Not defined: no `s_last` or `err` ports, and no check logic.

## Structure

- Package `upscale_pkg`:
  - state enum `{FILL, EMIT0, EMIT1}`.
  - Default `DATA_W`/`LINE_W` constants.
  - Index-width function.
- Sub-module `upscale_line_buf`:
  - `LINE_W x DATA_W` register bank with write enable, write index and read index.
  - No reset on the storage.
  - Write-enable implemented as a hold-mux around each storage bit.
- The controller holds the FSM, counters, output registers and the optional check logic.

## Test plan

Scenarios 1–5 use `DATA_W=8`, `LINE_W=4`.

1. Reset: assert `rst_n=0` mid-cycle → `m_valid=0`, `m_eol=0`, `m_data=0`, `s_ready=1` immediately, without waiting for a clock edge.
2. Row 0x10,0x20,0x30,0x40 with `s_valid=1` and `m_ready=1`:
   - From the next cycle: 16 consecutive beats 10,10,20,20,30,30,40,40 repeated twice.
   - `m_eol` on beats 8 and 16.
   - `s_ready=0` throughout, and `s_ready=1` the cycle after beat 16.
3. Backpressure: `m_ready` pseudo-random, about 50% low → the same 16-beat sequence, with no drop or duplicate; `m_data` and `m_eol` stable on every stalled cycle.
4. Input gaps: `s_valid` low for 3 clks between each pixel → EMIT starts 1 clk after the 4th handshake; output identical to scenario 2.
5. Reset on beat 5 of EMIT0 → outputs cleared; after release, row 1,2,3,4 yields 1,1,2,2,3,3,4,4 ×2 with no stale data.
6. With `UPSCALE_LAST_CHECK_EN`: `s_last=1` on pixel index 1 → `err=1` from the next clk and held through later correct rows; a correct row after reset leaves `err=0`.
